// File: rtl/pipe_stage_q.sv
// pipe_stage_q: elastic pipeline stage built on a DEPTH-entry circular queue.
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   flush      discard all entries; overrides enqueue and dequeue
//   in_valid   upstream offers in_data
//   in_data    upstream payload
//   in_ready   stage can accept this cycle
//   out_valid  out_data holds the oldest entry
//   out_data   oldest entry, always read from storage
//   out_ready  downstream accepts this cycle
//   count      current occupancy, 0..DEPTH
module pipe_stage_q #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned PASS_READY = 0,
  localparam int unsigned CW        = (DEPTH + 1 > 2) ? $clog2(DEPTH + 1) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CW-1:0]    count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [CW-1:0]    cnt;
  logic             full;
  logic             enq;
  logic             deq;
  logic [PW-1:0]    wp_nxt;
  logic [PW-1:0]    rp_nxt;

  // Handshake decode; flush masks both sides so nothing transfers during it.
  always_comb begin
    full      = (cnt == CW'(DEPTH));
    out_valid = (cnt != CW'(0)) & ~flush;
    if (PASS_READY != 0) begin
      // A full queue can take a new entry into the slot being freed this cycle.
      in_ready = (~full | out_ready) & ~flush;
    end else begin
      in_ready = ~full & ~flush;
    end
    enq      = in_valid & in_ready;
    deq      = out_valid & out_ready;
    out_data = mem[rp];
    count    = cnt;
  end

  // Pointer increment with explicit wrap, so DEPTH need not be a power of two.
  always_comb begin
    wp_nxt = (wp == PW'(DEPTH - 1)) ? PW'(0) : wp + PW'(1);
    rp_nxt = (rp == PW'(DEPTH - 1)) ? PW'(0) : rp + PW'(1);
  end

  // Queue state and storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp  <= PW'(0);
      rp  <= PW'(0);
      cnt <= CW'(0);
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= WIDTH'(0);
      end
    end else if (flush) begin
      wp  <= PW'(0);
      rp  <= PW'(0);
      cnt <= CW'(0);
    end else begin
      if (enq) begin
        mem[wp] <= in_data;
        wp      <= wp_nxt;
      end
      if (deq) begin
        rp <= rp_nxt;
      end
      if (enq && !deq) begin
        cnt <= cnt + CW'(1);
      end else if (deq && !enq) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: doc/pipe_stage_q.md
# pipe_stage_q

Parametrised elastic pipeline stage for the in-order core: a DEPTH-entry circular queue with valid/ready handshakes on both sides, same-cycle flush and an occupancy output. It sits between any two pipeline stages (fetch→decode, decode→execute, …) and replaces fixed single-register stage latches where back-pressure and buffering are needed. WIDTH carries the packed stage-data struct.

## Interface
Parameters:
- WIDTH, 64, payload width in bits (≥1)
- DEPTH, 2, number of storage entries (≥1, need not be a power of two)
- PASS_READY, 0, 1 = a full queue may accept while dequeuing in the same cycle (combinational out_ready→in_ready path); 0 = in_ready depends only on registered state and flush

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  discard all entries; dominates every other event
- in_valid  in  1  upstream offers in_data
- in_data  in  WIDTH  upstream payload
- in_ready  out  1  stage can accept this cycle
- out_valid  out  1  out_data holds the oldest entry
- out_data  out  WIDTH  oldest entry
- out_ready  in  1  downstream accepts this cycle
- count  out  CW = max(1, $clog2(DEPTH+1))  current occupancy, 0..DEPTH

## Operation
- enq = in_valid & in_ready; deq = out_valid & out_ready.
- Storage: DEPTH×WIDTH array, write pointer wp, read pointer rp, occupancy cnt; pointers wrap from DEPTH-1 to 0 explicitly (no modulo-2^n assumption).
- enq: mem[wp] ← in_data, wp advances. deq: rp advances. Both: cnt unchanged; otherwise cnt ±1.
- out_valid = (cnt != 0) & ~flush; out_data = mem[rp] (driven from storage, never from in_data — no input→output combinational path).
- in_ready, PASS_READY=0: (cnt != DEPTH) & ~flush.
- in_ready, PASS_READY=1: ((cnt != DEPTH) | out_ready) & ~flush. When full with deq and enq together, the write lands in the slot being freed (wp == rp); the read returns old data this cycle.
- flush=1: next cnt=0, wp=rp=0; in_ready and out_valid forced 0, so no enq or deq can occur; stored data contents are don't-care afterwards.
- count = cnt (registered, not affected combinationally by flush).
- Upstream must hold in_data/in_valid stable while in_valid & ~in_ready; out_data stays stable while out_valid & ~out_ready.

## Timing
- Reset (reset=0, asynchronous, any time): cnt=0, wp=rp=0, all mem entries = 0; outputs immediately out_valid=0, out_data=0, count=0, in_ready = ~flush.
- Reset release: first edge with reset=1 behaves as a normal cycle.
- Latency: entry accepted at edge N is visible (out_valid=1) after edge N; minimum residency 1 cycle.
- Throughput: 1 transfer/cycle sustained when DEPTH≥2 or PASS_READY=1; DEPTH=1 with PASS_READY=0 gives 1 transfer per 2 cycles under continuous flow.
- Full (cnt=DEPTH): in_ready=0 unless PASS_READY=1 & out_ready=1.
- Empty (cnt=0): out_valid=0; enq and deq cannot both occur (no fall-through).
- Wrap: after DEPTH enq/deq pairs pointers return to 0; ordering preserved across wrap.
- Flush concurrent with in_valid or out_ready: both ignored; queue empty next cycle.
- Reset asserted mid-transfer: in-flight entries lost, no partial state retained.

## Test plan
- Reset: drive reset=0 mid-stream with cnt=2 → out_valid=0, count=0, out_data=0 immediately, in_ready=1 after release.
- Fill/drain, DEPTH=3, PASS_READY=0: enqueue 0xA1,0xA2,0xA3 with out_ready=0 → count=3, in_ready=0; then out_ready=1 → outputs 0xA1,0xA2,0xA3 on consecutive cycles, count 2,1,0.
- Wrap: DEPTH=3, stream 10 values 1..10 with out_ready toggling random → received in order 1..10, no loss or duplication, count never >3.
- PASS_READY=1, DEPTH=2, full with 0x11,0x22, in_valid=1 with 0x33 and out_ready=1 → in_ready=1, 0x11 consumed, count stays 2, next outputs 0x22 then 0x33; same stimulus with PASS_READY=0 → in_ready=0, count drops to 1.
- Flush: count=2, flush=1 with in_valid=1 and out_ready=1 in same cycle → in_ready=0, out_valid=0 that cycle, count=0 next cycle, neither value transferred.
- Throughput: DEPTH=1 PASS_READY=0 continuous in_valid/out_ready=1 for 20 cycles → exactly 10 transfers; DEPTH=2 → 19 transfers (first-cycle fill latency).
